// File: rtl/uart_tx_retrans_ctrl.sv
// UART transmit controller with parity and ack/resend-driven retransmission.
// The byte is buffered on accept so every retry sends a bit-identical frame.
module uart_tx_retrans_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MAX_RETRY    = 2,
    parameter int RESP_TIMEOUT = 1024,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx_serial,
    input  logic       resend_req,
    input  logic       rx_ack,
    input  logic       err_clear,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] retries
);

    localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] CLK_ONE   = CLK_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RESP_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [3:0]       LAST_BIT  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    function automatic logic frame_parity(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Bits that follow the start bit, LSB first: d0..d7, parity, stop.
    function automatic logic [9:0] frame_tail(input logic [7:0] d);
        return {1'b1, frame_parity(d), d};
    endfunction

    state_e            state_q,   state_d;
    logic [7:0]        data_q,    data_d;
    logic [9:0]        shift_q,   shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]        retries_q, retries_d;
    logic              tx_q,      tx_d;
    logic              ready_q,   ready_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              error_q,   error_d;
    logic              accept_s;
    logic              retry_s;

    assign accept_s = data_valid & ready_q;
    assign retry_s  = resend_req | (tmo_cnt_q == TMO_LAST);

    // Next-state and next-output computation for the transmit FSM.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        retries_d = retries_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    data_d    = data_in;
                    retries_d = 2'd0;
                    state_d   = ST_SEND;
                    shift_d   = frame_tail(data_in);
                    bit_cnt_d = 4'd0;
                    clk_cnt_d = '0;
                    tx_d      = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end

            ST_SEND: begin
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_WAIT;
                        tmo_cnt_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[9:1]};
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end

            // Resend and timeout fold into one retry event; resend beats ack.
            ST_WAIT: begin
                if (retry_s) begin
                    if (retries_q < RETRY_MAX) begin
                        retries_d = retries_q + 2'd1;
                        state_d   = ST_SEND;
                        shift_d   = frame_tail(data_q);
                        bit_cnt_d = 4'd0;
                        clk_cnt_d = '0;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = ST_FAIL;
                        tx_d    = 1'b1;
                    end
                end else if (rx_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    tx_d      = 1'b1;
                end
            end

            ST_FAIL: begin
                tx_d = 1'b1;
                if (err_clear) begin
                    state_d   = ST_IDLE;
                    retries_d = 2'd0;
                end else begin
                    state_d = ST_FAIL;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_SEND) || (state_d == ST_WAIT);
        error_d = (state_d == ST_FAIL);
    end

    // State and registered outputs; reset drives the line idle immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            data_q    <= 8'd0;
            shift_q   <= 10'd0;
            bit_cnt_q <= 4'd0;
            clk_cnt_q <= '0;
            tmo_cnt_q <= '0;
            retries_q <= 2'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            retries_q <= retries_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign data_ready = ready_q;
    assign tx_serial  = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign retries    = retries_q;

endmodule

// File: doc/uart_tx_retrans_ctrl.md
Name: uart_tx_retrans_ctrl

Overview:
Transmit-side counterpart of the UART receive retransmission FSM. Accepts one byte from the host, serialises it as a UART frame with parity, and waits for the far-end receiver to respond with an ack or a resend request. On a resend request or a response timeout it retransmits the same byte, up to MAX_RETRY times, then flags an error. Sits between the host byte interface and the tx pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
MAX_RETRY, 2, retransmissions allowed after the first send
RESP_TIMEOUT, 1024, cycles in WAIT_RESP with no response before an implicit resend
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
data_in  input  8  byte to send; sampled on accept
data_valid  input  1  host offers data_in
data_ready  output  1  block can accept; accept = data_valid & data_ready
tx_serial  output  1  UART line, idle high
resend_req  input  1  receiver's resend request (NACK), single-cycle pulse
rx_ack  input  1  receiver accepted frame, single-cycle pulse
err_clear  input  1  host clears error state
busy  output  1  high in SEND or WAIT_RESP
done  output  1  one-cycle pulse on acknowledged delivery
error  output  1  level; high in FAIL
retries  output  2  retransmissions used for the current byte

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx_serial=1, data_ready=0, busy=0, done=0, error=0, retries=0, bit and timeout counters=0. data_ready rises at the first clk edge after reset deasserts.
- All outputs are registered. data_ready is 1 only in IDLE.
- States: IDLE, SEND, WAIT_RESP, FAIL.
- IDLE: on accept, latch data_in into the frame buffer, set retries=0, go to SEND. The start bit appears on tx_serial from the edge after accept.
- SEND frame: 11 bits, each held exactly CLKS_PER_BIT cycles.
  - start bit = 0
  - d0..d7, LSB first
  - parity bit = ^data (even parity), or ~^data when PARITY_ODD=1
  - stop bit = 1
  - Total frame time: 11*CLKS_PER_BIT cycles. After the stop bit completes, go to WAIT_RESP, tx_serial=1, timeout counter=0.
- WAIT_RESP:
  - rx_ack=1 with resend_req=0: go to IDLE, done=1 for exactly one cycle.
  - resend_req=1, or timeout counter reaching RESP_TIMEOUT-1: retry event.
  - resend_req has priority when rx_ack and resend_req arrive in the same cycle.
  - Timeout and resend in the same cycle count as a single retry event.
- Retry event:
  - If retries < MAX_RETRY: retries++, go to SEND with the same buffered byte (bit-identical frame).
  - Otherwise: go to FAIL.
- FAIL: error=1, tx_serial=1, busy=0, data_ready=0. When err_clear=1: go to IDLE, error=0, retries=0.
- Ignored inputs:
  - rx_ack and resend_req are ignored outside WAIT_RESP, including during SEND.
  - err_clear is ignored outside FAIL.
  - data_valid is ignored unless in IDLE.
- Counters never wrap. The bit counter restarts at 0 on every SEND entry; the timeout counter restarts at 0 on every WAIT_RESP entry.
- Reset mid-frame: tx_serial returns to 1 immediately (asynchronously). The frame is abandoned and no done or error is produced.

Test Plan:
- CLKS_PER_BIT=4, RESP_TIMEOUT=32. Accept 0xA5 -> tx_serial carries 0,1,0,1,0,0,1,0,1,0(parity),1, each for 4 cycles (44 cycles total). rx_ack 5 cycles later -> done one-cycle pulse, data_ready=1, retries=0.
- Send 0x3C, resend_req once in WAIT_RESP, then rx_ack -> second frame identical to the first, retries=1, done pulses once, error=0.
- Send 0x01 with resend_req after each of 3 frames -> exactly 3 frames transmitted, then error=1, tx_serial=1, data_ready=0. err_clear -> error=0, retries=0, data_ready=1.
- Send 0xFF with no response -> retransmit starts 32 cycles after the stop bit. On the second WAIT_RESP, assert rx_ack and resend_req in the same cycle -> a retransmit occurs (retries=2) and no done pulse.
- Assert reset=0 during data bit 3 of 0x55 -> tx_serial=1 within the same cycle, busy=0, no done. After release, data_ready=1 one edge later and a new byte transmits correctly.
- Pulse rx_ack and resend_req during SEND, and hold data_valid=1 while busy -> no state change, no new accept, frame timing unaltered.
